mem_port_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port data/instruction RAM between up to four bus requesters, e.g. `exec_unit` and a DMA/debug loader. Each requester presents a one-word read or write command. The arbiter grants one command per cycle, drives the registered command onto the RAM port, and returns read data with a one-hot `rvalid`. It sits between the requesters and the RAM, replacing the direct `exec_unit`-to-RAM wiring.

---
 rtl/constants_pkg.sv | 13 +
 rtl/rr_picker.sv | 33 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared RAM widths and memory-port arbiter state encoding
package constants_pkg;

    localparam int MEMORY_ADDRESS_BITS = 8;
    localparam int MEMORY_DATA_BITS    = 8;

    typedef enum bit [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_LOCKED
    } ArbState;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first eligible index at or above rr_ptr, wrapping
module rr_picker #(
    parameter int N        = 2,
    parameter int IDX_BITS = 1
) (
    input  logic [N-1:0]        elig,
    input  logic [IDX_BITS-1:0] rr_ptr,
    output logic [N-1:0]        win_onehot,
    output logic [IDX_BITS-1:0] win_idx,
    output logic                any
);

    logic [N-1:0]      rot;
    logic [IDX_BITS:0] sum;

    always_comb begin
        // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit then wins.
        rot = N'({elig, elig} >> rr_ptr);
        any = |elig;
        sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = (IDX_BITS + 1)'(k) + {1'b0, rr_ptr};
            end
        end
        if (sum >= (IDX_BITS + 1)'(N)) begin
            sum = sum - (IDX_BITS + 1)'(N);
        end
        win_idx    = sum[IDX_BITS-1:0];
        win_onehot = any ? (N'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one RAM port; MEM_ARB_LOCK_EN enables lock ownership
module mem_port_arbiter
    import constants_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = MEMORY_ADDRESS_BITS,
    parameter int DATA_BITS = MEMORY_DATA_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   wdata,
    input  logic [NUM_REQ-1:0]             lock,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_BITS-1:0]           rdata,
    output logic                           ram_rd_en,
    output logic [ADDR_BITS-1:0]           ram_rd_addr,
    input  logic [DATA_BITS-1:0]           ram_rd_data,
    output logic                           ram_wr_en,
    output logic [ADDR_BITS-1:0]           ram_wr_addr,
    output logic [DATA_BITS-1:0]           ram_wr_data
);

    localparam int IDX_BITS = $clog2(NUM_REQ);

    ArbState               state_q, state_d;
    logic [IDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    elig, win_oh, gnt_d, rvalid_d;
    logic [IDX_BITS-1:0]   win_idx;
    logic                  win_any;
    logic                  rd_en_d, wr_en_d, sel_we;
    logic [ADDR_BITS-1:0]  rd_addr_d, wr_addr_d, sel_addr;
    logic [DATA_BITS-1:0]  wr_data_d, sel_wdata;

`ifdef MEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]    owner_q, owner_d;
    logic                  sel_lock;
`else
    logic                  unused_lock_cfg;
    assign unused_lock_cfg = ^lock ^ (state_q == ARB_LOCKED);
`endif

    assign rdata = ram_rd_data;

    rr_picker #(.N(NUM_REQ), .IDX_BITS(IDX_BITS)) u_picker (
        .elig       (elig),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (win_oh),
        .win_idx    (win_idx),
        .any        (win_any)
    );

    always_comb begin
        // The requester granted this cycle is masked so a held req is not granted twice.
        elig      = req & ~gnt;
        state_d   = ARB_IDLE;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = '0;
        rvalid_d  = ram_rd_en ? gnt : '0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        rd_addr_d = ram_rd_addr;
        wr_addr_d = ram_wr_addr;
        wr_data_d = ram_wr_data;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        owner_d   = owner_q;
        sel_lock  = 1'b0;
        if (state_q == ARB_LOCKED && |(owner_q & req & lock)) begin
            elig = owner_q;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_BITS +: ADDR_BITS];
                sel_wdata = wdata[i*DATA_BITS +: DATA_BITS];
`ifdef MEM_ARB_LOCK_EN
                sel_lock  = lock[i];
`endif
            end
        end
        if (win_any) begin
            gnt_d    = win_oh;
            state_d  = ARB_GRANT;
            rr_ptr_d = (win_idx == IDX_BITS'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (sel_we) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr;
                wr_data_d = sel_wdata;
            end else begin
                rd_en_d   = 1'b1;
                rd_addr_d = sel_addr;
            end
`ifdef MEM_ARB_LOCK_EN
            if (sel_lock) begin
                state_d = ARB_LOCKED;
                owner_d = win_oh;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            gnt         <= '0;
            rvalid      <= '0;
            ram_rd_en   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_rd_addr <= '0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
`ifdef MEM_ARB_LOCK_EN
            owner_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt         <= gnt_d;
            rvalid      <= rvalid_d;
            ram_rd_en   <= rd_en_d;
            ram_wr_en   <= wr_en_d;
            ram_rd_addr <= rd_addr_d;
            ram_wr_addr <= wr_addr_d;
            ram_wr_data <= wr_data_d;
`ifdef MEM_ARB_LOCK_EN
            owner_q     <= owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter against a behavioural model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import constants_pkg::*;

    localparam int N  = 2;
    localparam int AB = MEMORY_ADDRESS_BITS;
    localparam int DB = MEMORY_DATA_BITS;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req = '0, we = '0, lock = '0;
    logic [N*AB-1:0]   addr = '0;
    logic [N*DB-1:0]   wdata = '0;
    logic [N-1:0]      gnt, rvalid;
    logic [DB-1:0]     rdata;
    logic              ram_rd_en, ram_wr_en;
    logic [AB-1:0]     ram_rd_addr, ram_wr_addr;
    logic [DB-1:0]     ram_wr_data;
    logic [DB-1:0]     ram_rd_data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .lock        (lock),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data)
    );

    function automatic logic [DB-1:0] init_val(int i);
        if (i == 16) return DB'(8'hA5);
        return DB'(i * 29 + 7);
    endfunction

    // Synchronous-read RAM attached to the port, loaded at the first edge.
    logic [DB-1:0] ram [0:(1<<AB)-1];
    bit            ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < (1 << AB); i++) ram[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else begin
            if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
            if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one grant per edge picked by scanning from the pointer.
    logic [DB-1:0] model_mem [0:(1<<AB)-1];
    logic [N-1:0]  m_gnt = '0, m_rvalid = '0, m_el;
    logic          m_rd_en = 1'b0, m_wr_en = 1'b0;
    logic [AB-1:0] m_rd_addr = '0, m_wr_addr = '0, m_a;
    logic [DB-1:0] m_wr_data = '0, m_rdata = '0, m_pend = '0, m_d;
    int            m_ptr = 0, m_owner = 0, m_w;
    bit            m_locked = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_gnt = '0; m_rvalid = '0; m_rd_en = 1'b0; m_wr_en = 1'b0;
            m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0;
            m_ptr = 0; m_locked = 1'b0;
        end else begin
            m_rvalid = m_rd_en ? m_gnt : '0;
            m_rdata  = m_pend;
            m_el     = req & ~m_gnt;
`ifdef MEM_ARB_LOCK_EN
            if (m_locked && req[m_owner] && lock[m_owner]) begin
                m_el = '0;
                m_el[m_owner] = 1'b1;
            end
`endif
            m_w = -1;
            for (int k = 0; k < N; k++)
                if (m_w < 0 && m_el[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            m_gnt = '0; m_rd_en = 1'b0; m_wr_en = 1'b0; m_locked = 1'b0;
            if (m_w >= 0) begin
                m_gnt[m_w] = 1'b1;
                m_ptr = (m_w + 1) % N;
                m_a = addr[m_w*AB +: AB];
                m_d = wdata[m_w*DB +: DB];
                if (we[m_w]) begin
                    m_wr_en = 1'b1; m_wr_addr = m_a; m_wr_data = m_d;
                    model_mem[m_a] = m_d;
                end else begin
                    m_rd_en = 1'b1; m_rd_addr = m_a;
                    m_pend = model_mem[m_a];
                end
`ifdef MEM_ARB_LOCK_EN
                if (lock[m_w]) begin
                    m_locked = 1'b1;
                    m_owner = m_w;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("m_gnt",     32'(gnt),         32'(m_gnt));
        check("m_rvalid",  32'(rvalid),      32'(m_rvalid));
        check("m_rd_en",   32'(ram_rd_en),   32'(m_rd_en));
        check("m_wr_en",   32'(ram_wr_en),   32'(m_wr_en));
        check("m_rd_addr", 32'(ram_rd_addr), 32'(m_rd_addr));
        check("m_wr_addr", 32'(ram_wr_addr), 32'(m_wr_addr));
        check("m_wr_data", 32'(ram_wr_data), 32'(m_wr_data));
        if (m_rvalid != '0) check("m_rdata", 32'(rdata), 32'(m_rdata));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(int i, logic r, logic w, logic [AB-1:0] a, logic [DB-1:0] d);
        req[i] = r;
        we[i]  = w;
        addr[i*AB +: AB]  = a;
        wdata[i*DB +: DB] = d;
    endtask

    logic [N-1:0] alt_seq [6];

    initial begin
        for (int i = 0; i < (1 << AB); i++) model_mem[i] = init_val(i);
        alt_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

        // Reset held three cycles with every requester asking.
        reset = 1'b1;
        set_cmd(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 8'h02, 8'h00);
        tick; tick; tick;
        check("rst_gnt",     32'(gnt),         32'h0);
        check("rst_rvalid",  32'(rvalid),      32'h0);
        check("rst_rd_en",   32'(ram_rd_en),   32'h0);
        check("rst_wr_en",   32'(ram_wr_en),   32'h0);
        check("rst_rd_addr", 32'(ram_rd_addr), 32'h0);
        check("rst_wr_data", 32'(ram_wr_data), 32'h0);
        reset = 1'b0;
        tick;
        check("first_gnt",  32'(gnt),         32'h1);
        check("first_addr", 32'(ram_rd_addr), 32'h01);
        req = '0;
        tick;
        check("first_rvalid", 32'(rvalid), 32'h1);

        // Single read by requester 1.
        set_cmd(1, 1'b1, 1'b0, 8'h10, 8'h00);
        tick;
        check("rd_gnt",  32'(gnt),         32'h2);
        check("rd_addr", 32'(ram_rd_addr), 32'h10);
        check("rd_en",   32'(ram_rd_en),   32'h1);
        req = '0;
        tick;
        check("rd_rvalid", 32'(rvalid), 32'h2);
        check("rd_rdata",  32'(rdata),  32'hA5);

        // Contention: both held high, grants must alternate.
        set_cmd(0, 1'b1, 1'b0, 8'h30, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 8'h31, 8'h00);
        for (int c = 0; c < 6; c++) begin
            tick;
            check("alt_gnt", 32'(gnt), 32'(alt_seq[c]));
        end
        req = '0;
        tick; tick;

        // Write then read back through the other requester.
        set_cmd(0, 1'b1, 1'b1, 8'h20, 8'h3C);
        tick;
        check("wr_gnt",   32'(gnt),         32'h1);
        check("wr_en",    32'(ram_wr_en),   32'h1);
        check("wr_addr",  32'(ram_wr_addr), 32'h20);
        check("wr_data",  32'(ram_wr_data), 32'h3C);
        req[0] = 1'b0;
        set_cmd(1, 1'b1, 1'b0, 8'h20, 8'h00);
        tick;
        check("wr_rd_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick;
        check("wr_rd_rvalid", 32'(rvalid), 32'h2);
        check("wr_rd_rdata",  32'(rdata),  32'h3C);

        // Reset during the grant cycle of a read.
        set_cmd(0, 1'b1, 1'b0, 8'h10, 8'h00);
        tick;
        check("mid_gnt", 32'(gnt), 32'h1);
        reset = 1'b1;
        req = '0;
        tick;
        check("mid_rvalid", 32'(rvalid), 32'h0);
        reset = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 8'h11, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 8'h12, 8'h00);
        tick;
        check("mid_ptr_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick; tick;

`ifdef MEM_ARB_LOCK_EN
        set_cmd(1, 1'b1, 1'b0, 8'h40, 8'h00);
        tick;
        req = '0;
        tick; tick;
        lock = 2'b01;
        set_cmd(0, 1'b1, 1'b0, 8'h41, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 8'h42, 8'h00);
        for (int c = 0; c < 4; c++) begin
            tick;
            check("lock_gnt", 32'(gnt), 32'h1);
        end
        lock = '0;
        tick;
        check("unlock_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick; tick;
`endif

        // Randomized traffic with occasional resets; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] || gnt[i]) begin
                    set_cmd(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                            AB'($urandom_range(0, 15)), DB'($urandom));
                end
                lock[i] = ($urandom_range(0, 2) == 0);
            end
            tick;
        end
        reset = 1'b0;
        req = '0;
        tick; tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
